multicycle_controller: RTL and testbench

Sequential successor to the combinational main decoder. It sequences each MIPS instruction through FETCH, DECODE, EXEC, MEM and WB states over multiple cycles, and generates per-state control strobes. Memory wait states are handled through a `Mem_Ready` handshake, multiply latency is parametrisable, and external stalls and illegal-opcode trapping are supported. It sits between the instruction register and the shared datapath (single unified memory port, one ALU, register file).

---
 rtl/multicycle_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives per-state
// datapath strobes, with memory handshake, multi-cycle mul, external stall and illegal trap.
module multicycle_controller #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Mem_Ready,
  input  logic       Branch_Taken,
  input  logic       Stall,
  output logic       IR_Write,
  output logic       PC_Write,
  output logic [1:0] PC_Src,
  output logic       IorD,
  output logic       R_Enable,
  output logic       W_Enable,
  output logic [1:0] R_Width,
  output logic [1:0] W_Width,
  output logic [1:0] RegDst,
  output logic       ALUSrc0,
  output logic [1:0] ALUSrc1,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsNone,
    ClsAlu,
    ClsShift,
    ClsJr,
    ClsMul,
    ClsAluImm,
    ClsLw,
    ClsLh,
    ClsLb,
    ClsSw,
    ClsSh,
    ClsSb,
    ClsBranch,
    ClsJ,
    ClsJal
  } cls_e;

  localparam logic [CNT_W-1:0] MulLast = CNT_W'(MUL_LAT - 1);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  cls_e             dec_cls;
  logic             dec_legal;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;

  logic             cls_load;
  logic             cls_store;
  logic [1:0]       cls_width;
  logic             cls_rdst;

  // Instruction classification straight from the IR fields; only consumed in DECODE.
  always_comb begin
    dec_cls   = ClsNone;
    dec_legal = 1'b1;
    case (Opcode)
      6'b000000: begin
        case (Funct)
          6'b000000, 6'b000010: dec_cls = ClsShift;
          6'b001000:            dec_cls = ClsJr;
          default:              dec_cls = ClsAlu;
        endcase
      end
      6'b011100: dec_cls = ClsMul;
      6'b100011: dec_cls = ClsLw;
      6'b100001: dec_cls = ClsLh;
      6'b100000: dec_cls = ClsLb;
      6'b101011: dec_cls = ClsSw;
      6'b101001: dec_cls = ClsSh;
      6'b101000: dec_cls = ClsSb;
      6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: dec_cls = ClsBranch;
      6'b000010: dec_cls = ClsJ;
      6'b000011: dec_cls = ClsJal;
      6'b001000, 6'b001010, 6'b001101, 6'b001110: dec_cls = ClsAluImm;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    cls_load  = cls_q inside {ClsLw, ClsLh, ClsLb};
    cls_store = cls_q inside {ClsSw, ClsSh, ClsSb};
    cls_rdst  = cls_q inside {ClsAlu, ClsShift, ClsJr, ClsMul};
    case (cls_q)
      ClsLh, ClsSh: cls_width = 2'd1;
      ClsLb, ClsSb: cls_width = 2'd2;
      default:      cls_width = 2'd0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= StFetch;
      cls_q     <= ClsNone;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    if (!Stall) begin
      case (state_q)
        StFetch: begin
          if (Mem_Ready) state_d = StDecode;
        end
        StDecode: begin
          if (dec_legal) begin
            cls_d   = dec_cls;
            state_d = StExec;
          end else begin
            illegal_d = 1'b1;
            state_d   = StTrap;
          end
        end
        StExec: begin
          cnt_d = '0;
          case (cls_q)
            ClsBranch, ClsJ, ClsJal, ClsJr:           state_d = StFetch;
            ClsLw, ClsLh, ClsLb, ClsSw, ClsSh, ClsSb: state_d = StMem;
            ClsMul: begin
              if (cnt_q == MulLast) begin
                state_d = StWb;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            default: state_d = StWb;
          endcase
        end
        StMem: begin
          if (Mem_Ready) state_d = cls_load ? StWb : StFetch;
        end
        StWb:    state_d = StFetch;
        StTrap:  state_d = StTrap;
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    IR_Write = 1'b0;
    PC_Write = 1'b0;
    PC_Src   = 2'd0;
    IorD     = 1'b0;
    R_Enable = 1'b0;
    W_Enable = 1'b0;
    R_Width  = 2'd0;
    W_Width  = 2'd0;
    RegDst   = 2'd0;
    ALUSrc0  = 1'b0;
    ALUSrc1  = 2'd0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    Illegal  = 1'b0;
    State    = 3'd0;
    if (Reset_n) begin
      State   = state_q;
      Illegal = illegal_q;
      case (state_q)
        StFetch: begin
          R_Enable = 1'b1;
          if (Mem_Ready) begin
            IR_Write = 1'b1;
            PC_Write = 1'b1;
          end
        end
        StExec: begin
          if (cls_rdst) RegDst = 2'd1;
          case (cls_q)
            ClsShift: ALUSrc0 = 1'b1;
            ClsAluImm, ClsLw, ClsLh, ClsLb, ClsSw, ClsSh, ClsSb: ALUSrc1 = 2'd1;
            ClsBranch: begin
              PC_Src   = 2'd1;
              PC_Write = Branch_Taken;
            end
            ClsJ: begin
              PC_Src   = 2'd2;
              PC_Write = 1'b1;
            end
            ClsJal: begin
              PC_Src   = 2'd2;
              PC_Write = 1'b1;
              RegWrite = 1'b1;
              RegDst   = 2'd2;
              ALUSrc1  = 2'd2;
            end
            ClsJr: begin
              PC_Src   = 2'd3;
              PC_Write = 1'b1;
            end
            default: ;
          endcase
        end
        StMem: begin
          IorD = 1'b1;
          if (cls_load) begin
            R_Enable = 1'b1;
            R_Width  = cls_width;
          end
          if (cls_store) begin
            W_Enable = 1'b1;
            W_Width  = cls_width;
          end
        end
        StWb: begin
          RegWrite = 1'b1;
          MemToReg = !cls_load;
          RegDst   = cls_rdst ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
      // A stall freezes architectural side effects but leaves reads and selects visible.
      if (Stall) begin
        IR_Write = 1'b0;
        PC_Write = 1'b0;
        RegWrite = 1'b0;
        W_Enable = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized traffic,
// every cycle compared against a phase-queue reference model built from per-opcode rules.
module tb_multicycle_controller;

  localparam int unsigned MulLat = 3;
  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PT = 5;

  logic       Clk = 1'b0;
  logic       Reset_n, Mem_Ready, Branch_Taken, Stall;
  logic [5:0] Opcode, Funct;
  logic       IR_Write, PC_Write, IorD, R_Enable, W_Enable, ALUSrc0, MemToReg, RegWrite, Illegal;
  logic [1:0] PC_Src, R_Width, W_Width, RegDst, ALUSrc1;
  logic [2:0] State;
  logic [31:0] obs;

  multicycle_controller #(
    .MUL_LAT(MulLat),
    .CNT_W  (4)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Opcode      (Opcode),
    .Funct       (Funct),
    .Mem_Ready   (Mem_Ready),
    .Branch_Taken(Branch_Taken),
    .Stall       (Stall),
    .IR_Write    (IR_Write),
    .PC_Write    (PC_Write),
    .PC_Src      (PC_Src),
    .IorD        (IorD),
    .R_Enable    (R_Enable),
    .W_Enable    (W_Enable),
    .R_Width     (R_Width),
    .W_Width     (W_Width),
    .RegDst      (RegDst),
    .ALUSrc0     (ALUSrc0),
    .ALUSrc1     (ALUSrc1),
    .MemToReg    (MemToReg),
    .RegWrite    (RegWrite),
    .Illegal     (Illegal),
    .State       (State)
  );

  always #5 Clk = ~Clk;

  assign obs = {10'd0, IR_Write, PC_Write, PC_Src, IorD, R_Enable, W_Enable, R_Width, W_Width,
                RegDst, ALUSrc0, ALUSrc1, MemToReg, RegWrite, Illegal, State};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: remaining phases of the current instruction, plus decoded fields.
  int         phq[$];
  logic [5:0] m_op, m_fn;
  bit         m_ill;

  function automatic bit is_load(input logic [5:0] op);
    return op inside {6'h23, 6'h21, 6'h20};
  endfunction
  function automatic bit is_store(input logic [5:0] op);
    return op inside {6'h2b, 6'h29, 6'h28};
  endfunction
  function automatic bit is_branch(input logic [5:0] op);
    return op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
  endfunction
  function automatic bit is_alu_imm(input logic [5:0] op);
    return op inside {6'h08, 6'h0a, 6'h0d, 6'h0e};
  endfunction
  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h1c || op == 6'h02 || op == 6'h03 || is_load(op) ||
           is_store(op) || is_branch(op) || is_alu_imm(op);
  endfunction
  function automatic logic [1:0] mem_width(input logic [5:0] op);
    if (op == 6'h23 || op == 6'h2b) return 2'd0;
    if (op == 6'h21 || op == 6'h29) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] exp_out(input bit rst_n, input bit st, input bit mr,
                                          input bit bt);
    logic       irw, pcw, iord, ren, wen, a0, m2r, rw;
    logic [1:0] pcs, rwd, wwd, rd, a1;
    logic [2:0] ps;
    bit         rtype, mul, ld, sd;
    {irw, pcw, iord, ren, wen, a0, m2r, rw} = '0;
    {pcs, rwd, wwd, rd, a1} = '0;
    if (!rst_n) return 32'd0;
    ps    = 3'(phq[0]);
    rtype = (m_op == 6'h00);
    mul   = (m_op == 6'h1c);
    ld    = is_load(m_op);
    sd    = is_store(m_op);
    case (phq[0])
      PF: begin
        ren = 1'b1;
        if (mr && !st) begin
          irw = 1'b1;
          pcw = 1'b1;
        end
      end
      PE: begin
        if (rtype && (m_fn == 6'h00 || m_fn == 6'h02)) a0 = 1'b1;
        if (rtype || mul) rd = 2'd1;
        if (is_alu_imm(m_op) || ld || sd) a1 = 2'd1;
        if (is_branch(m_op)) begin
          pcs = 2'd1;
          pcw = bt && !st;
        end
        if (m_op == 6'h02) begin
          pcs = 2'd2;
          pcw = !st;
        end
        if (m_op == 6'h03) begin
          pcs = 2'd2;
          pcw = !st;
          rw  = !st;
          rd  = 2'd2;
          a1  = 2'd2;
        end
        if (rtype && m_fn == 6'h08) begin
          pcs = 2'd3;
          pcw = !st;
        end
      end
      PM: begin
        iord = 1'b1;
        if (ld) begin
          ren = 1'b1;
          rwd = mem_width(m_op);
        end
        if (sd) begin
          wen = !st;
          wwd = mem_width(m_op);
        end
      end
      PW: begin
        rw  = !st;
        m2r = !ld;
        rd  = (rtype || mul) ? 2'd1 : 2'd0;
      end
      default: ;
    endcase
    return {10'd0, irw, pcw, pcs, iord, ren, wen, rwd, wwd, rd, a0, a1, m2r, rw, m_ill, ps};
  endfunction

  task automatic model_step(input bit rst_n, input bit st, input bit mr, input logic [5:0] op,
                            input logic [5:0] fn);
    if (!rst_n) begin
      phq   = {};
      m_ill = 1'b0;
    end else if (!st) begin
      case (phq[0])
        PF: if (mr) begin
          void'(phq.pop_front());
          phq.push_back(PD);
        end
        PD: begin
          void'(phq.pop_front());
          m_op = op;
          m_fn = fn;
          if (!is_legal(op)) begin
            m_ill = 1'b1;
            phq.push_back(PT);
          end else begin
            repeat ((op == 6'h1c) ? MulLat : 1) phq.push_back(PE);
            if (is_load(op) || is_store(op)) phq.push_back(PM);
            if (is_load(op) || op == 6'h1c || is_alu_imm(op) || (op == 6'h00 && fn != 6'h08))
              phq.push_back(PW);
          end
        end
        PE, PW: void'(phq.pop_front());
        PM: if (mr) void'(phq.pop_front());
        default: ;
      endcase
    end
    if (phq.size() == 0) phq.push_back(PF);
  endtask

  logic [31:0] snap_obs;
  logic [2:0]  snap_state;
  logic [1:0]  snap_pcs, snap_rwd, snap_rd;
  logic        snap_ren, snap_rw, snap_m2r, snap_pcw, snap_ill;

  // One clock: drive at negedge, compare mid-cycle, advance the model at posedge.
  task automatic cyc(input bit rst_n, input bit st, input bit mr, input bit bt,
                     input logic [5:0] op, input logic [5:0] fn);
    @(negedge Clk);
    Reset_n      = rst_n;
    Stall        = st;
    Mem_Ready    = mr;
    Branch_Taken = bt;
    Opcode       = op;
    Funct        = fn;
    #2;
    check($sformatf("cycle ph%0d op%02h", phq[0], m_op), obs, exp_out(rst_n, st, mr, bt));
    snap_obs   = obs;
    snap_state = State;
    snap_ren   = R_Enable;
    snap_rw    = RegWrite;
    snap_m2r   = MemToReg;
    snap_rd    = RegDst;
    snap_pcw   = PC_Write;
    snap_pcs   = PC_Src;
    snap_rwd   = R_Width;
    snap_ill   = Illegal;
    @(posedge Clk);
    model_step(rst_n, st, mr, op, fn);
  endtask

  logic [5:0] op_tab [21] = '{6'h00, 6'h00, 6'h00, 6'h1c, 6'h23, 6'h21, 6'h20, 6'h2b, 6'h29,
                              6'h28, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03, 6'h08,
                              6'h0d, 6'h0e, 6'h0a};
  logic [2:0] mul_seq [6] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4};

  initial begin
    int unsigned rw_pulses;
    Reset_n = 1'b0; Stall = 1'b0; Mem_Ready = 1'b1; Branch_Taken = 1'b0;
    Opcode = 6'h00; Funct = 6'h00;
    m_op = 6'h00; m_fn = 6'h00; m_ill = 1'b0;
    phq.push_back(PF);

    repeat (3) begin
      cyc(0, 0, 1, 1, 6'h23, 6'h00);
      check("reset_outputs", snap_obs, 32'd0);
    end

    // lw: release cycle is the first of two FETCH waits, then two MEM waits.
    cyc(1, 0, 0, 0, 6'h23, 6'h00);
    check("release_state", 32'(snap_state), 32'd0);
    check("release_ren", 32'(snap_ren), 32'd1);
    cyc(1, 0, 0, 0, 6'h23, 6'h00);
    cyc(1, 0, 1, 0, 6'h23, 6'h00);
    cyc(1, 0, 1, 0, 6'h23, 6'h00);
    cyc(1, 0, 1, 0, 6'h23, 6'h00);
    cyc(1, 0, 0, 0, 6'h23, 6'h00);
    cyc(1, 0, 0, 0, 6'h23, 6'h00);
    cyc(1, 0, 1, 0, 6'h23, 6'h00);
    check("lw_mem_state", 32'(snap_state), 32'd3);
    check("lw_mem_rwidth", 32'(snap_rwd), 32'd0);
    cyc(1, 0, 1, 0, 6'h23, 6'h00);
    check("lw_wb_regwrite", 32'(snap_rw), 32'd1);
    check("lw_wb_memtoreg", 32'(snap_m2r), 32'd0);
    check("lw_wb_regdst", 32'(snap_rd), 32'd0);

    // mul: FETCH, DECODE, three EXEC, WB.
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 1, 0, 6'h1c, 6'h02);
      check($sformatf("mul_state%0d", i), 32'(snap_state), 32'(mul_seq[i]));
    end
    check("mul_wb_regdst", 32'(snap_rd), 32'd1);
    check("mul_wb_memtoreg", 32'(snap_m2r), 32'd1);

    for (int t = 1; t >= 0; t--) begin
      cyc(1, 0, 1, 0, 6'h04, 6'h00);
      check("beq_fetch_state", 32'(snap_state), 32'd0);
      cyc(1, 0, 1, 0, 6'h04, 6'h00);
      cyc(1, 0, 1, t[0], 6'h04, 6'h00);
      check("beq_pcwrite", 32'(snap_pcw), 32'(t));
      check("beq_pcsrc", 32'(snap_pcs), 32'd1);
    end

    // addi stalled twice in WB.
    cyc(1, 0, 1, 0, 6'h08, 6'h00);
    check("beq_return_state", 32'(snap_state), 32'd0);
    cyc(1, 0, 1, 0, 6'h08, 6'h00);
    cyc(1, 0, 1, 0, 6'h08, 6'h00);
    rw_pulses = 0;
    repeat (2) begin
      cyc(1, 1, 1, 0, 6'h08, 6'h00);
      check("stall_wb_state", 32'(snap_state), 32'd4);
      check("stall_wb_regwrite", 32'(snap_rw), 32'd0);
    end
    cyc(1, 0, 1, 0, 6'h08, 6'h00);
    rw_pulses += 32'(snap_rw);
    cyc(1, 0, 1, 0, 6'h08, 6'h00);
    rw_pulses += 32'(snap_rw);
    check("addi_regwrite_pulses", rw_pulses, 32'd1);

    // Illegal opcode traps and stays silent until reset.
    cyc(1, 0, 1, 0, 6'h3f, 6'h00);
    cyc(1, 0, 1, 0, 6'h3f, 6'h00);
    repeat (10) begin
      cyc(1, 0, 1, 1, 6'h00, 6'h20);
      check("trap_illegal", 32'(snap_ill), 32'd1);
      check("trap_state", 32'(snap_state), 32'd5);
      check("trap_strobes", snap_obs >> 4, 32'd0);
    end
    cyc(0, 0, 1, 0, 6'h00, 6'h00);
    cyc(1, 0, 0, 0, 6'h00, 6'h00);
    check("trap_cleared", 32'(snap_ill), 32'd0);

    repeat (4000) begin
      bit         r, s, m, b;
      logic [5:0] op, fn;
      r  = $urandom_range(99) >= ((phq[0] == PT) ? 15 : 1);
      s  = $urandom_range(99) < 20;
      m  = $urandom_range(99) < 60;
      b  = $urandom_range(1) == 1;
      op = ($urandom_range(99) < 4) ? 6'($urandom_range(63)) : op_tab[$urandom_range(20)];
      case ($urandom_range(3))
        0:       fn = 6'h00;
        1:       fn = 6'h02;
        2:       fn = 6'h08;
        default: fn = 6'($urandom_range(63));
      endcase
      cyc(r, s, m, b, op, fn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
